// File: rtl/mode_step_controller_pkg.sv
// Shared encodings and reset values for the mode/step sequencer.
package mode_step_controller_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam logic [1:0] MODE_INC  = 2'b00;
    localparam logic [1:0] MODE_DEC  = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b10;
    localparam logic [1:0] MODE_INC2 = 2'b11;

    localparam logic [1:0] Q_RST    = 2'd0;
    localparam logic [1:0] MODE_RST = MODE_HOLD;

    function automatic logic [3:0] onehot(input logic [1:0] v);
        return 4'b0001 << v;
    endfunction

endpackage

// File: rtl/mode_step_controller_debounce_sync.sv
// Accepts an already-synchronized vector only after CYCLES consecutive differing cycles.
module debounce_sync #(
    parameter int             W       = 1,
    parameter int             CYCLES  = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [W-1:0]     dout_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            dout_reg <= RST_VAL;
        end else if (din != dout_reg) begin
            // The first differing cycle sees cnt==0, so the CYCLES-th one sees CYCLES-1.
            if (cnt_reg == CNT_W'(CYCLES - 1)) begin
                dout_reg <= din;
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end else begin
            cnt_reg <= '0;
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/mode_step_controller_step_next_state.sv
// Combinational next-state arithmetic: mod-4 step selected by the applied mode.
module step_next_state
    import mode_step_controller_pkg::*;
(
    input  logic [1:0] sw,
    input  logic [1:0] q,
    output logic [1:0] next_q
);

    always_comb begin
        next_q = q;
        case (sw)
            MODE_INC:  next_q = q + 2'd1;
            MODE_DEC:  next_q = q - 2'd1;
            MODE_HOLD: next_q = q;
            MODE_INC2: next_q = q + 2'd2;
            default:   next_q = q;
        endcase
    end

endmodule

// File: rtl/mode_step_controller.sv
// Mode/step sequencer: input sync + debounce, run divider, control FSM and the q/LED registers.
module mode_step_controller
    import mode_step_controller_pkg::*;
#(
    parameter int DIV_COUNT       = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    input  logic       btn_step,
    input  logic       run_en,
    output logic [1:0] q,
    output logic [3:0] leds,
    output logic [1:0] mode,
    output logic       step_pulse,
    output logic       running
);

    localparam int DIV_W = $clog2(DIV_COUNT);

    // Bit order: {run_en, btn_step, sw[1:0]}
    logic [3:0] sync1_reg, sync2_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= {run_en, btn_step, sw};
            sync2_reg <= sync1_reg;
        end
    end

    logic [1:0] sw_s;
    logic       btn_s;
    logic       run_en_s;
    assign sw_s     = sync2_reg[1:0];
    assign btn_s    = sync2_reg[2];
    assign run_en_s = sync2_reg[3];

    logic [1:0] mode_db;
    logic       btn_db;

    debounce_sync #(.W(2), .CYCLES(DEBOUNCE_CYCLES), .RST_VAL(MODE_RST)) u_sw_db (
        .clk  (clk),
        .rst  (rst),
        .din  (sw_s),
        .dout (mode_db)
    );

    debounce_sync #(.W(1), .CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_btn_db (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_s),
        .dout (btn_db)
    );

    logic btn_prev_reg;
    logic btn_rise;
    assign btn_rise = btn_db & ~btn_prev_reg;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_reg;
    logic             tick;
    logic             advance;

    assign tick = (state_reg == S_RUN) && (div_reg == DIV_W'(DIV_COUNT - 1));

    always_comb begin
        state_next = state_reg;
        advance    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // Run takes priority; a simultaneous button edge is dropped.
                if (run_en_s)      state_next = S_RUN;
                else if (btn_rise) state_next = S_STEP;
            end
            S_RUN: begin
                advance = tick;
                if (!run_en_s) state_next = S_IDLE;
            end
            S_STEP: begin
                advance    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    logic [1:0] next_q;
    logic [1:0] q_reg;
    logic [1:0] q_new;
    logic [3:0] leds_reg;
    logic       step_pulse_reg;
    logic       running_reg;

    step_next_state u_next (
        .sw     (mode_db),
        .q      (q_reg),
        .next_q (next_q)
    );

    assign q_new = advance ? next_q : q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            div_reg        <= '0;
            btn_prev_reg   <= 1'b0;
            q_reg          <= Q_RST;
            leds_reg       <= onehot(Q_RST);
            step_pulse_reg <= 1'b0;
            running_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            btn_prev_reg <= btn_db;
            // Divider only advances while staying in RUN; leaving RUN clears it.
            if (state_reg == S_RUN && state_next == S_RUN)
                div_reg <= tick ? '0 : div_reg + 1'b1;
            else
                div_reg <= '0;
            q_reg          <= q_new;
            leds_reg       <= onehot(q_new);
            step_pulse_reg <= advance;
            running_reg    <= (state_next == S_RUN);
        end
    end

    assign q          = q_reg;
    assign leds       = leds_reg;
    assign mode       = mode_db;
    assign step_pulse = step_pulse_reg;
    assign running    = running_reg;

endmodule

// File: tb/tb_mode_step_controller.sv
// Directed bench for mode_step_controller with DIV_COUNT=4, DEBOUNCE_CYCLES=3.
module tb_mode_step_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sw;
    logic       btn_step;
    logic       run_en;
    logic [1:0] q;
    logic [3:0] leds;
    logic [1:0] mode;
    logic       step_pulse;
    logic       running;

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;
    int snap;

    mode_step_controller #(.DIV_COUNT(4), .DEBOUNCE_CYCLES(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .btn_step   (btn_step),
        .run_en     (run_en),
        .q          (q),
        .leds       (leds),
        .mode       (mode),
        .step_pulse (step_pulse),
        .running    (running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (step_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] t=%0t %s observed=%0h expected=%0h", $time, tag, obs, exp);
    endtask

    // Called just after an advance edge; checks the next advance DIV_COUNT cycles later.
    task automatic run_period(input logic [1:0] exp_q);
        cyc(3);
        chk("no_pulse_between", 8'(step_pulse), 8'd0);
        cyc(1);
        chk("q_adv", 8'(q), 8'(exp_q));
        chk("leds_adv", 8'(leds), 8'(4'b0001 << exp_q));
        chk("pulse_adv", 8'(step_pulse), 8'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_q"}, 8'(q), 8'd0);
        chk({tag, "_leds"}, 8'(leds), 8'h01);
        chk({tag, "_mode"}, 8'(mode), 8'h02);
        chk({tag, "_pulse"}, 8'(step_pulse), 8'd0);
        chk({tag, "_running"}, 8'(running), 8'd0);
    endtask

    initial begin
        rst = 1'b1; sw = 2'b10; btn_step = 1'b0; run_en = 1'b0;
        cyc(3);
        rst = 1'b0;
        chk_reset_state("reset");
        cyc(5);
        chk("idle_mode", 8'(mode), 8'h02);

        // Free run, increment mode
        sw = 2'b00; run_en = 1'b1;
        cyc(2);
        chk("run_not_yet", 8'(running), 8'd0);
        cyc(1);
        chk("run_entered", 8'(running), 8'd1);
        chk("mode_still_hold", 8'(mode), 8'h02);
        cyc(1);
        chk("mode_lat4", 8'(mode), 8'h02);
        cyc(1);
        chk("mode_lat5", 8'(mode), 8'h00);
        cyc(1);
        chk("q_before_tick", 8'(q), 8'd0);
        chk("pulse_before_tick", 8'(step_pulse), 8'd0);
        cyc(1);
        chk("q_first", 8'(q), 8'd1);
        chk("pulse_first", 8'(step_pulse), 8'd1);
        chk("leds_first", 8'(leds), 8'h02);
        run_period(2'd2);
        run_period(2'd3);
        run_period(2'd0);

        // Decrement, then +2, then hold (mode applied at the advance after it settles)
        sw = 2'b01;
        run_period(2'd1);
        run_period(2'd0);
        run_period(2'd3);
        run_period(2'd2);
        run_period(2'd1);
        sw = 2'b11;
        run_period(2'd0);
        run_period(2'd2);
        run_period(2'd0);
        run_period(2'd2);
        sw = 2'b10;
        run_period(2'd0);
        run_period(2'd0);
        run_period(2'd0);
        chk("mode_hold", 8'(mode), 8'h02);

        // Back to increment, then a 2-cycle glitch that must be rejected
        sw = 2'b00;
        run_period(2'd0);
        run_period(2'd1);
        sw = 2'b01;
        cyc(2);
        sw = 2'b00;
        cyc(1);
        chk("glitch_mode", 8'(mode), 8'h00);
        cyc(1);
        chk("glitch_q", 8'(q), 8'd2);
        chk("glitch_pulse", 8'(step_pulse), 8'd1);
        run_period(2'd3);
        chk("glitch_mode_after", 8'(mode), 8'h00);

        // Asynchronous reset in the middle of running
        #2 rst = 1'b1;
        #1;
        chk_reset_state("midrst");
        run_en = 1'b0; sw = 2'b00;
        cyc(2);
        rst = 1'b0;
        cyc(8);
        chk("post_rst_mode", 8'(mode), 8'h00);
        chk("post_rst_q", 8'(q), 8'd0);
        chk("post_rst_running", 8'(running), 8'd0);

        // Manual step: long press gives exactly one advance
        btn_step = 1'b1;
        cyc(6);
        chk("step_wait_q", 8'(q), 8'd0);
        chk("step_wait_pulse", 8'(step_pulse), 8'd0);
        cyc(1);
        chk("step_q", 8'(q), 8'd1);
        chk("step_pulse", 8'(step_pulse), 8'd1);
        chk("step_leds", 8'(leds), 8'h02);
        cyc(1);
        chk("step_pulse_end", 8'(step_pulse), 8'd0);
        snap = pulse_cnt;
        cyc(2);
        btn_step = 1'b0;
        cyc(10);
        chk("step_hold_q", 8'(q), 8'd1);
        chk("step_hold_pulses", 8'(pulse_cnt - snap), 8'd0);

        // Button press while running is ignored
        run_en = 1'b1;
        cyc(6);
        chk("run2_running", 8'(running), 8'd1);
        chk("run2_q_wait", 8'(q), 8'd1);
        cyc(1);
        chk("run2_q", 8'(q), 8'd2);
        chk("run2_pulse", 8'(step_pulse), 8'd1);
        btn_step = 1'b1;
        snap = pulse_cnt;
        run_period(2'd3);
        run_period(2'd0);
        btn_step = 1'b0;
        run_period(2'd1);
        chk("run2_pulse_count", 8'(pulse_cnt - snap), 8'd3);

        // Leave run mode
        run_en = 1'b0;
        cyc(12);
        chk("pause_running", 8'(running), 8'd0);
        chk("pause_q", 8'(q), 8'd1);
        chk("pause_pulse", 8'(step_pulse), 8'd0);

        // run_en rises in the same cycle as the button edge: run wins, no step
        btn_step = 1'b1;
        cyc(3);
        run_en = 1'b1;
        cyc(2);
        chk("race_not_yet", 8'(running), 8'd0);
        cyc(1);
        chk("race_running", 8'(running), 8'd1);
        snap = pulse_cnt;
        cyc(3);
        chk("race_no_step_q", 8'(q), 8'd1);
        chk("race_no_step_pulses", 8'(pulse_cnt - snap), 8'd0);
        cyc(1);
        chk("race_first_q", 8'(q), 8'd2);
        chk("race_first_pulse", 8'(step_pulse), 8'd1);

        btn_step = 1'b0;
        run_en = 1'b0;
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
